stdcore_rpack: RTL and testbench
================================

// Module: stdcore_rpack
// PURPOSE
//  Stream packer on the consumer side of the standard read FIFO: takes narrow DW words
//  over a val/rdy handshake and emits one RATIO*DW word per RATIO accepted beats.
//  s_last closes a partial word early, flagged by lane-keep and last.
//  Sits between a FIFO's c/c_val/c_rdy port and a wide consumer (bus or memory write stage).
// PARAMETERS
//  DW     8  width of one input word (>=1)
//  RATIO  4  input words per output word (>=2)
//  CW     2  lane counter width; must satisfy 2**CW >= RATIO
// PORTS
//  clk     in   1         clock; all state updates on rising edge
//  rst     in   1         reset, synchronous, active-high
//  s       in   DW        input word
//  s_val   in   1         input valid
//  s_rdy   out  1         input ready
//  s_last  in   1         input word is the last of its burst; closes the current output word
//  m       out  DW*RATIO  packed word; lane i = bits [i*DW +: DW], lane 0 = first accepted beat
//  m_keep  out  RATIO     per-lane valid mask for m
//  m_last  out  1         output word was closed by s_last
//  m_val   out  1         output valid (registered)
//  m_rdy   in   1         output ready
// BEHAVIOUR
//  - Clock/reset fixed: single clock clk; rst synchronous active-high, overrides every other input.
//  - Reset values: m=0, m_keep=0, m_last=0, m_val=0, lane counter cnt=0, accumulator acc=0.
//    s_rdy=1 during the cycle after reset.
//  - Transfers: s_acc = s_val & s_rdy; m_acc = m_val & m_rdy.
//  - s_rdy = ~m_val | m_rdy. This is combinational from m_rdy; there is no path from s_val.
//  - Accept without completion (s_acc & ~s_last & cnt != RATIO-1):
//    acc lane[cnt] <= s; cnt <= cnt+1.
//  - Completion (s_acc & (s_last | cnt == RATIO-1)). The new beat bypasses acc:
//    - m <= acc lanes [0..cnt-1] with s in lane cnt; lanes above cnt are 0.
//    - m_keep <= (2 << cnt) - 1; m_last <= s_last; m_val <= 1.
//    - cnt <= 0; acc <= 0.
//  - Output register: when m_acc and no completion in the same cycle, m_val <= 0.
//    m/m_keep/m_last hold their value until the next completion.
//  - Simultaneous m_acc and completion: the new word replaces the old one with m_val held at 1.
//    Sustained rate is one input beat per cycle.
//  - Latency: a completing beat is visible on m the cycle after its s_acc.
//  - Stall: while m_val & ~m_rdy, s_rdy=0. acc, cnt and m are all held stable.
//  - s_last on the first beat (cnt=0) gives m_keep = 1.
//    s_last together with cnt == RATIO-1 gives a full word with m_last=1.
//  - Reset mid-word discards the partial acc and any pending output; no flush is issued.
//  - cnt never exceeds RATIO-1; no wrap state other than the return to 0 on completion.
// STRUCTURE
//  - No typedefs. Lane-index arithmetic uses CW-bit unsigned.
//  - (2 << cnt) - 1 is computed in RATIO+1 bits, then truncated to RATIO.
//  - Shared constant/function include: width check macro (2**CW >= RATIO), elaboration-time
//    error on violation.
//  - One natural sub-module, stdcore_rpack_oreg: the output register
//    (m/m_keep/m_last/m_val load, hold, clear) with load/ready inputs.
//  - Lane accumulator and counter stay in the top level.
// TESTING (DW=8, RATIO=4)
//  1. Beats 0x11,0x22,0x33,0x44 back-to-back with m_rdy=1
//     -> next cycle m=0x44332211, m_keep=4'b1111, m_last=0, m_val=1 for exactly 1 cycle.
//  2. Beats 0xAA, then 0xBB with s_last=1
//     -> m=0x0000BBAA, m_keep=4'b0011, m_last=1.
//     Then single beat 0x5C with s_last -> m=0x0000005C, m_keep=4'b0001.
//  3. m_val=1 with m_rdy=0 for 5 cycles
//     -> s_rdy=0 and m stable throughout.
//     m_rdy=1 -> s_rdy=1 in the same cycle; the word is consumed and m_val drops next cycle
//     unless a completion coincides.
//  4. 12 consecutive beats 0x01..0x0C with m_rdy=1
//     -> s_rdy constantly 1; three words 0x04030201, 0x08070605, 0x0C0B0A09
//        on m at 4-cycle spacing.
//  5. Accept 0x01,0x02, assert rst 1 cycle, then 0x10,0x20,0x30,0x40
//     -> m_val=0 after rst; only output is 0x40302010 with m_keep=4'b1111.
//  6. Random s_val/m_rdy with random s_last over 10k beats
//     -> scoreboard matches lanes, keep and last; no beat lost or duplicated.

Source files
------------

// File: rtl/stdcore_rpack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stdcore_rpack_pkg
// Purpose  : Shared helpers for the stream packer (lane-counter width check).
// Revision : 1.0 - initial release
// ============================================================================
package stdcore_rpack_pkg;

  // True when a CW-bit lane counter can index every one of RATIO lanes.
  function automatic bit cw_fits(input int cw, input int ratio);
    return (2 ** cw) >= ratio;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stdcore_rpack_oreg.sv
`default_nettype none
// ============================================================================
// Module   : stdcore_rpack_oreg
// Purpose  : Output register of the packer: loads a completed word, holds it
//            until the consumer takes it, then clears valid.
// Revision : 1.0 - initial release
// ============================================================================
module stdcore_rpack_oreg #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  rdy,
  input  logic [DW*RATIO-1:0]   d_word,
  input  logic [RATIO-1:0]      d_keep,
  input  logic                  d_last,
  output logic [DW*RATIO-1:0]   m,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_last,
  output logic                  m_val
);

  // Load wins over consume so a back-to-back completion keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m      <= '0;
      m_keep <= '0;
      m_last <= 1'b0;
      m_val  <= 1'b0;
    end else if (load) begin
      m      <= d_word;
      m_keep <= d_keep;
      m_last <= d_last;
      m_val  <= 1'b1;
    end else if (m_val && rdy) begin
      m_val  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stdcore_rpack.sv
`default_nettype none
// ============================================================================
// Module   : stdcore_rpack
// Purpose  : Packs RATIO narrow DW-bit beats into one wide word; s_last closes
//            a partial word early (reported through m_keep and m_last).
// Revision : 1.0 - initial release
// ============================================================================
module stdcore_rpack
  import stdcore_rpack_pkg::*;
#(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s,
  input  logic                  s_val,
  output logic                  s_rdy,
  input  logic                  s_last,
  output logic [DW*RATIO-1:0]   m,
  output logic [RATIO-1:0]      m_keep,
  output logic                  m_last,
  output logic                  m_val,
  input  logic                  m_rdy
);

  // Elaboration-time parameter sanity checks.
  if (!cw_fits(CW, RATIO)) begin : g_cw_check
    $error("stdcore_rpack: 2**CW must be >= RATIO");
  end
  if (RATIO < 2) begin : g_ratio_check
    $error("stdcore_rpack: RATIO must be >= 2");
  end
  if (DW < 1) begin : g_dw_check
    $error("stdcore_rpack: DW must be >= 1");
  end

  localparam logic [CW-1:0] c_last_lane = CW'(RATIO - 1);

  logic [CW-1:0]       r_cnt;
  logic [DW*RATIO-1:0] r_acc;
  logic [DW*RATIO-1:0] w_word;
  logic [RATIO-1:0]    w_keep;
  logic                w_s_acc;
  logic                w_complete;

  // Input is free whenever the output slot is empty or being drained now.
  assign s_rdy      = ~m_val | m_rdy;
  assign w_s_acc    = s_val & s_rdy;
  assign w_complete = w_s_acc & (s_last | (r_cnt == c_last_lane));

  // Thermometer mask of lanes 0..cnt, formed one bit wider so cnt=RATIO-1 does not overflow.
  assign w_keep = RATIO'(((RATIO + 1)'(2) << r_cnt) - (RATIO + 1)'(1));

  // Per-lane accumulator and completed-word assembly; the completing beat bypasses acc.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    // Fill this lane when it is the current slot of an unfinished word.
    always_ff @(posedge clk) begin
      if (rst || w_complete) begin
        r_acc[i*DW +: DW] <= '0;
      end else if (w_s_acc && (r_cnt == CW'(i))) begin
        r_acc[i*DW +: DW] <= s;
      end
    end

    assign w_word[i*DW +: DW] = (CW'(i) < r_cnt)  ? r_acc[i*DW +: DW] :
                                (CW'(i) == r_cnt) ? s                 : '0;
  end

  // Lane counter: advances per accepted beat, returns to 0 on completion.
  always_ff @(posedge clk) begin
    if (rst || w_complete) begin
      r_cnt <= '0;
    end else if (w_s_acc) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  stdcore_rpack_oreg #(
    .DW    (DW),
    .RATIO (RATIO)
  ) u_oreg (
    .clk    (clk),
    .rst    (rst),
    .load   (w_complete),
    .rdy    (m_rdy),
    .d_word (w_word),
    .d_keep (w_keep),
    .d_last (s_last),
    .m      (m),
    .m_keep (m_keep),
    .m_last (m_last),
    .m_val  (m_val)
  );

endmodule
`default_nettype wire

// File: tb/tb_stdcore_rpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdcore_rpack
// Purpose  : Self-checking bench for stdcore_rpack (DW=8, RATIO=4) against a
//            beat-list reference model with a queue of expected output words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdcore_rpack;

  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int CW    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [DW-1:0]       s;
  logic                s_val;
  logic                s_rdy;
  logic                s_last;
  logic [DW*RATIO-1:0] m;
  logic [RATIO-1:0]    m_keep;
  logic                m_last;
  logic                m_val;
  logic                m_rdy;

  always #5 clk = ~clk;

  stdcore_rpack #(.DW(DW), .RATIO(RATIO), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .s      (s),
    .s_val  (s_val),
    .s_rdy  (s_rdy),
    .s_last (s_last),
    .m      (m),
    .m_keep (m_keep),
    .m_last (m_last),
    .m_val  (m_val),
    .m_rdy  (m_rdy)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: beats of the open word, plus completed words awaiting the consumer.
  logic [31:0] part;
  int          n;
  logic [31:0] qd[$];
  logic [3:0]  qk[$];
  logic        ql[$];
  int          beats;

  // Snapshot of the outputs taken in the most recent cycle.
  logic [31:0] obs_m;
  logic [3:0]  obs_keep;
  logic        obs_last;
  logic        obs_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    part = '0;
    n    = 0;
    qd.delete();
    qk.delete();
    ql.delete();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic sa;
    logic ma;
    @(negedge clk);
    rst = 1'b0; s_val = v; s = d; s_last = l; m_rdy = r;
    #1;
    obs_m = m; obs_keep = m_keep; obs_last = m_last; obs_val = m_val;
    chk("s_rdy", s_rdy, (qd.size() == 0) || r);
    chk("m_val", m_val, qd.size() != 0);
    if (qd.size() != 0) begin
      chk("m", m, qd[0]);
      chk("m_keep", m_keep, qk[0]);
      chk("m_last", m_last, ql[0]);
    end
    sa = v && ((qd.size() == 0) || r);
    ma = (qd.size() != 0) && r;
    if (ma) begin
      void'(qd.pop_front());
      void'(qk.pop_front());
      void'(ql.pop_front());
    end
    if (sa) begin
      part[n*8 +: 8] = d;
      n++;
      beats++;
      if (l || n == RATIO) begin
        qd.push_back(part);
        qk.push_back(4'((1 << n) - 1));
        ql.push_back(l);
        part = '0;
        n    = 0;
      end
    end
  endtask

  // One reset cycle with live-looking inputs, followed by a reset-state check.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_val = 1'b1; s = 8'hEE; s_last = 1'b1; m_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_m", m, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_last", m_last, 0);
    chk("rst_val", m_val, 0);
    chk("rst_s_rdy", s_rdy, 1);
    model_clear();
  endtask

  initial begin
    int rbeats;
    int cycles;
    rst = 1'b1; s = '0; s_val = 1'b0; s_last = 1'b0; m_rdy = 1'b0;
    beats = 0;
    model_clear();
    do_reset();

    // Full word, then output valid for exactly one cycle.
    cyc(1, 8'h11, 0, 1); cyc(1, 8'h22, 0, 1); cyc(1, 8'h33, 0, 1); cyc(1, 8'h44, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t1_m", obs_m, 32'h44332211);
    chk("t1_keep", obs_keep, 4'b1111);
    chk("t1_last", obs_last, 0);
    chk("t1_val", obs_val, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t1_val_drop", obs_val, 0);

    // Early close with two beats, then a single-beat word.
    cyc(1, 8'hAA, 0, 1); cyc(1, 8'hBB, 1, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t2_m", obs_m, 32'h0000BBAA);
    chk("t2_keep", obs_keep, 4'b0011);
    chk("t2_last", obs_last, 1);
    cyc(1, 8'h5C, 1, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t2b_m", obs_m, 32'h0000005C);
    chk("t2b_keep", obs_keep, 4'b0001);

    // Stall: output held 5 cycles with input offered, then released.
    cyc(1, 8'hA1, 0, 1); cyc(1, 8'hA2, 0, 1); cyc(1, 8'hA3, 0, 1); cyc(1, 8'hA4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'hF0 + 8'(i), 0, 0);
      chk("t3_hold", obs_m, 32'hA4A3A2A1);
    end
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t3_drop", obs_val, 0);

    // Twelve back-to-back beats.
    for (int i = 1; i <= 12; i++) cyc(1, 8'(i), 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t4_m3", obs_m, 32'h0C0B0A09);

    // Reset mid-word discards the partial beats.
    cyc(1, 8'h01, 0, 1); cyc(1, 8'h02, 0, 1);
    do_reset();
    cyc(1, 8'h10, 0, 1); cyc(1, 8'h20, 0, 1); cyc(1, 8'h30, 0, 1); cyc(1, 8'h40, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t5_m", obs_m, 32'h40302010);
    chk("t5_keep", obs_keep, 4'b1111);

    // Randomized traffic, bounded by a cycle budget.
    rbeats = beats;
    cycles = 0;
    while ((beats - rbeats) < 10000 && cycles < 60000) begin
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 7);
      cycles++;
    end
    chk("rand_beats", beats - rbeats, 10000);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
